// File: rtl/mux4to1_rr.sv
// 4:1 valid/ready stream multiplexer with round-robin arbitration and a registered output stage.
// Define MUX4TO1_FIXED_PRIO_EN to replace round-robin with fixed priority (channel 0 highest).
module mux4to1_rr #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t       state;
    out_state_t       state_next;
    logic [1:0]       ptr;
    logic [1:0]       grant;
    logic             grant_valid;
    logic [1:0]       search_idx;
    logic             load_en;
    logic             transfer;
    logic [WIDTH-1:0] chan_data [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign out_valid = (state == FULL);
    assign load_en   = ~out_valid | out_ready;

    // First valid channel at or after ptr wins; ptr is pinned to 0 in the fixed-priority build.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 2'b00;
        search_idx  = 2'b00;
        for (int k = 0; k < 4; k++) begin
            search_idx = ptr + 2'(k);
            if (!grant_valid && in_valid[search_idx]) begin
                grant_valid = 1'b1;
                grant       = search_idx;
            end
        end
    end

    assign transfer = grant_valid & load_en & ~rst;
    assign in_ready = transfer ? (4'b0001 << grant) : 4'b0000;

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (transfer) state_next = FULL;
            FULL:    if (out_ready && !transfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Data and index hold their last values after a drain; only a transfer reloads them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= 2'b00;
        end else if (transfer) begin
            out_data <= chan_data[grant];
            out_sel  <= grant;
        end
    end

`ifdef MUX4TO1_FIXED_PRIO_EN
    assign ptr = 2'b00;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'b00;
        end else if (transfer) begin
            ptr <= grant + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux4to1_rr.sv
// Directed, table-driven bench for mux4to1_rr (round-robin build) with hand-written stall sequence.
module tb_mux4to1_rr;

    localparam int WIDTH = 8;
    localparam logic [31:0] DATA_ALL = 32'h4433_2211;

    logic               clk;
    logic               rst;
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  iv;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_ir;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_os;
    } vec_t;

    vec_t vecs[$];

    mux4to1_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] iv, input logic [31:0] d, input logic ordy);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    // in_ready is checked before the edge, the output register just after it.
    task automatic checkOutput(input string name, input logic [3:0] exp_ir, input logic exp_ov,
                               input logic [7:0] exp_od, input logic [1:0] exp_os);
        #1;
        checkValue({name, ".in_ready"}, 32'(in_ready), 32'(exp_ir));
        @(posedge clk);
        #1;
        checkValue({name, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
        checkValue({name, ".out_data"}, 32'(out_data), 32'(exp_od));
        checkValue({name, ".out_sel"}, 32'(out_sel), 32'(exp_os));
    endtask

    task automatic addVec(input string name, input logic r, input logic [3:0] iv, input logic [31:0] d,
                          input logic ordy, input logic [3:0] ir, input logic ov, input logic [7:0] od,
                          input logic [1:0] os);
        vec_t v;
        v.name = name; v.rst = r; v.iv = iv; v.data = d; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_os = os;
        vecs.push_back(v);
    endtask

    task automatic runTable();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].data, vecs[i].ordy);
            checkOutput(vecs[i].name, vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_os);
        end
        vecs.delete();
    endtask

    initial begin
        applyStimulus(1'b1, 4'b1111, DATA_ALL, 1'b1);

        addVec("reset0",   1, 4'b1111, DATA_ALL,      1, 4'b0000, 0, 8'h00, 2'd0);
        addVec("reset1",   1, 4'b1111, DATA_ALL,      1, 4'b0000, 0, 8'h00, 2'd0);
        addVec("idle",     0, 4'b0000, DATA_ALL,      1, 4'b0000, 0, 8'h00, 2'd0);
        addVec("single2",  0, 4'b0100, 32'h44A5_2211, 1, 4'b0100, 1, 8'hA5, 2'd2);
        addVec("drain",    0, 4'b0000, DATA_ALL,      1, 4'b0000, 0, 8'hA5, 2'd2);
        addVec("wrap0",    0, 4'b0011, DATA_ALL,      1, 4'b0001, 1, 8'h11, 2'd0);
        addVec("skip1",    0, 4'b0011, DATA_ALL,      1, 4'b0010, 1, 8'h22, 2'd1);
        addVec("only3",    0, 4'b1000, DATA_ALL,      1, 4'b1000, 1, 8'h44, 2'd3);
        for (int n = 0; n < 8; n++) begin
            addVec($sformatf("rr%0d", n), 0, 4'b1111, DATA_ALL, 1,
                   4'b0001 << (n % 4), 1, 8'h11 * 8'((n % 4) + 1), 2'(n % 4));
        end
        runTable();

        // Stall: hold the word for ch2 while all channels request, then release.
        applyStimulus(1'b0, 4'b0100, DATA_ALL, 1'b1);
        checkOutput("load2", 4'b0100, 1'b1, 8'h33, 2'd2);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 4'b1111, DATA_ALL ^ 32'(n + 1), 1'b0);
            checkOutput($sformatf("stall%0d", n), 4'b0000, 1'b1, 8'h33, 2'd2);
        end
        applyStimulus(1'b0, 4'b1111, DATA_ALL, 1'b1);
        checkOutput("release3", 4'b1000, 1'b1, 8'h44, 2'd3);
        applyStimulus(1'b0, 4'b0000, DATA_ALL, 1'b1);
        checkOutput("empty", 4'b0000, 1'b0, 8'h44, 2'd3);

        addVec("pre_rst",  0, 4'b1111, DATA_ALL, 1, 4'b0001, 1, 8'h11, 2'd0);
        addVec("mid_rst",  1, 4'b1111, DATA_ALL, 1, 4'b0000, 0, 8'h00, 2'd0);
        addVec("post_rst", 0, 4'b1111, DATA_ALL, 1, 4'b0001, 1, 8'h11, 2'd0);
        addVec("post_rr1", 0, 4'b1111, DATA_ALL, 1, 4'b0010, 1, 8'h22, 2'd1);
        runTable();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
